timer_multi: RTL and testbench
==============================

Name: timer_multi

Overview:
- Parametrised successor to the single-width free-running timer.
- Adds a programmable prescaler, a compare match in periodic or one-shot mode, synchronous clear/load, and overflow and done status.
- Sits beside the clock-domain measurement logic as a reusable event/timeout source.
- One clock; reset is asynchronous and active-high.

Parameters:
- WIDTH, 16, counter and compare/load width (2..32).
- PS_W, 8, prescaler width; tick every (prescale+1) enabled cycles.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- t_en  in  1  run enable; low pauses counting (state held).
- t_clear  in  1  synchronous clear of count, prescaler and state.
- t_load  in  1  synchronous load of load_val into count.
- load_val  in  WIDTH  value for t_load.
- prescale  in  PS_W  tick divider P.
- compare  in  WIDTH  match value.
- mode  in  1  0 = periodic (auto-reload 0), 1 = one-shot.
- t_out  out  WIDTH  current count.
- t_valid  out  1  1-cycle pulse: t_out just updated by a tick.
- t_match  out  1  1-cycle pulse on a compare-match event.
- t_ovf  out  1  1-cycle pulse on WIDTH wrap from all-ones to 0.
- t_done  out  1  level; one-shot completed.

Behaviour:
- Reset (async, active-high): count=0, pcnt=0, state=IDLE; t_out=0, t_valid=0, t_match=0, t_ovf=0, t_done=0.
- Registered FSM with states IDLE, RUN, DONE:
  - IDLE -> RUN on t_en=1.
  - RUN -> IDLE on t_en=0 (pause; count and pcnt held).
  - RUN -> DONE on a match tick when mode=1.
  - DONE -> IDLE on t_clear or t_load. t_en is ignored in DONE.
- Prescaler:
  - In RUN only, pcnt increments each cycle.
  - tick = (state==RUN) && (pcnt >= prescale); on tick, pcnt <= 0.
  - Using >= makes a mid-run decrease of prescale safe. P=0 ticks every RUN cycle.
- Tick update (count register, next edge):
  - If count==compare:
    - mode=0: count <= 0, t_match pulses.
    - mode=1: count holds compare, t_match pulses, state <= DONE.
  - Else if count == all-ones: count <= 0, t_ovf pulses.
  - Else: count <= count+1.
  - Arithmetic is modulo 2^WIDTH; there is no saturation.
- Periodic period = (compare+1)*(P+1) cycles.
- Pulse outputs are registered and aligned with the count update they describe. t_valid pulses on every tick.
- t_done = (state==DONE). It stays high until t_clear or t_load.
- Priority, highest first: reset > t_clear > t_load > tick.
  - t_clear: count=0, pcnt=0, state=IDLE, all pulses 0.
  - t_load: count=load_val, pcnt=0, state=IDLE (RUN next cycle if t_en=1). No pulses that cycle.
- compare changed mid-run takes effect on the next tick. If count is already past compare, counting continues up to all-ones, overflows, then matches on the next pass.
- Latency: t_en rising at edge N enters RUN at N+1. With P=0, the first t_valid and t_out=1 appear after edge N+2.

Optional Feature:
- Macro TIMER_MULTI_CAPTURE_EN.
- When defined, adds input cap_in (1 bit) and output cap_out (WIDTH).
- cap_out is loaded with t_out on each rising edge of cap_in, detected in the clock domain (cap_in assumed synchronous).
- cap_out resets to 0 and is cleared by t_clear.
- When undefined, both ports and the capture logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run at count=5 -> all outputs 0 immediately (async), before the next clock edge.
- mode=0, P=0, compare=3, t_en held high -> t_out sequence 1,2,3,0,1,...; t_match pulses with each 0; t_valid high every cycle from the first tick.
- mode=1, P=2, compare=2 -> t_out advances every 3 cycles: 1,2, then holds 2; t_match pulses once, then t_done=1 and stays high until t_clear.
- WIDTH=4, compare=15 in periodic mode, load_val=14 -> ticks give 15, then 0 with t_match=1 and t_ovf=0. Repeat with compare=3 from load 14: 15, then 0 with t_ovf=1.
- t_clear and t_load asserted in the same cycle during RUN -> count=0 (clear wins). t_en toggled low for 4 cycles -> t_out and pcnt frozen, resuming with the same phase.
- (TIMER_MULTI_CAPTURE_EN) cap_in rising while t_out=7 -> cap_out=7 on the next edge and held across later counts.

Source files
------------

// File: rtl/timer_multi.sv
// timer_multi: prescaled up-counter with compare match (periodic or one-shot), overflow and done status.
// Define TIMER_MULTI_CAPTURE_EN to add the cap_in/cap_out capture register.
module timer_multi #(
    parameter int WIDTH = 16,
    parameter int PS_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             t_en,
    input  logic             t_clear,
    input  logic             t_load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PS_W-1:0]  prescale,
    input  logic [WIDTH-1:0] compare,
    input  logic             mode,
`ifdef TIMER_MULTI_CAPTURE_EN
    input  logic             cap_in,
    output logic [WIDTH-1:0] cap_out,
`endif
    output logic [WIDTH-1:0] t_out,
    output logic             t_valid,
    output logic             t_match,
    output logic             t_ovf,
    output logic             t_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PS_W-1:0]  PCNT_ONE  = {{(PS_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_countNext;
    logic [PS_W-1:0]  r_pcnt;
    logic [PS_W-1:0]  w_pcntNext;
    logic             r_valid;
    logic             r_match;
    logic             r_ovf;
    logic             w_validNext;
    logic             w_matchNext;
    logic             w_ovfNext;
    logic             w_tick;
    logic             w_isMatch;
    logic             w_isMax;

    // >= keeps a mid-run decrease of prescale from stalling the divider
    assign w_tick    = (r_state == RUN) && (r_pcnt >= prescale);
    assign w_isMatch = (r_count == compare);
    assign w_isMax   = (r_count == {WIDTH{1'b1}});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_pcnt  <= '0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            r_pcnt  <= w_pcntNext;
            r_valid <= w_validNext;
            r_match <= w_matchNext;
            r_ovf   <= w_ovfNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_pcntNext  = r_pcnt;
        w_validNext = 1'b0;
        w_matchNext = 1'b0;
        w_ovfNext   = 1'b0;
        if (t_clear) begin
            w_stateNext = IDLE;
            w_countNext = '0;
            w_pcntNext  = '0;
        end else if (t_load) begin
            w_stateNext = IDLE;
            w_countNext = load_val;
            w_pcntNext  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (t_en) begin
                        w_stateNext = RUN;
                    end
                end
                RUN: begin
                    if (!t_en) begin
                        w_stateNext = IDLE;
                    end
                    if (w_tick) begin
                        w_pcntNext  = '0;
                        w_validNext = 1'b1;
                        if (w_isMatch) begin
                            w_matchNext = 1'b1;
                            if (mode) begin
                                w_stateNext = DONE;
                            end else begin
                                w_countNext = '0;
                            end
                        end else if (w_isMax) begin
                            w_countNext = '0;
                            w_ovfNext   = 1'b1;
                        end else begin
                            w_countNext = r_count + COUNT_ONE;
                        end
                    end else begin
                        w_pcntNext = r_pcnt + PCNT_ONE;
                    end
                end
                DONE: begin
                    w_stateNext = DONE;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    assign t_out   = r_count;
    assign t_valid = r_valid;
    assign t_match = r_match;
    assign t_ovf   = r_ovf;
    assign t_done  = (r_state == DONE);

`ifdef TIMER_MULTI_CAPTURE_EN
    logic             r_capPrev;
    logic [WIDTH-1:0] r_cap;

    // Snapshot the count on a rising edge of cap_in
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_capPrev <= 1'b0;
            r_cap     <= '0;
        end else begin
            r_capPrev <= cap_in;
            if (t_clear) begin
                r_cap <= '0;
            end else if (cap_in && !r_capPrev) begin
                r_cap <= r_count;
            end
        end
    end

    assign cap_out = r_cap;
`endif

endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: scoreboard bench for timer_multi (WIDTH=4 so wrap and overflow are reachable).
// Exercises periodic, one-shot, load/clear priority, pause, prescale and compare changes, async reset.
module tb_timer_multi;

    localparam int WIDTH = 4;
    localparam int PS_W  = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             t_en;
    logic             t_clear;
    logic             t_load;
    logic [WIDTH-1:0] load_val;
    logic [PS_W-1:0]  prescale;
    logic [WIDTH-1:0] compare;
    logic             mode;
    logic [WIDTH-1:0] t_out;
    logic             t_valid;
    logic             t_match;
    logic             t_ovf;
    logic             t_done;
`ifdef TIMER_MULTI_CAPTURE_EN
    logic             cap_in;
    logic [WIDTH-1:0] cap_out;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] cap;
        logic [WIDTH-1:0] out;
        logic             valid;
        logic             match;
        logic             ovf;
        logic             done;
    } exp_t;

    exp_t             expQ[$];
    int               checks = 0;
    int               failures = 0;
    logic [WIDTH-1:0] mCount;
    logic [PS_W-1:0]  mPcnt;
    int               mState;
    logic [WIDTH-1:0] mCap;
    logic             mCapPrev;

    timer_multi #(.WIDTH(WIDTH), .PS_W(PS_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .t_en     (t_en),
        .t_clear  (t_clear),
        .t_load   (t_load),
        .load_val (load_val),
        .prescale (prescale),
        .compare  (compare),
        .mode     (mode),
`ifdef TIMER_MULTI_CAPTURE_EN
        .cap_in   (cap_in),
        .cap_out  (cap_out),
`endif
        .t_out    (t_out),
        .t_valid  (t_valid),
        .t_match  (t_match),
        .t_ovf    (t_ovf),
        .t_done   (t_done)
    );

    always #5 clock = ~clock;

    // Hard stop if anything wedges
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCount   = '0;
        mPcnt    = '0;
        mState   = S_IDLE;
        mCap     = '0;
        mCapPrev = 1'b0;
        expQ.delete();
    endtask

    // Advance the reference model by one clock using the inputs just driven, queue the expectation
    task automatic applyStimulus();
        exp_t e;
        int   nState;
        e = '0;
`ifdef TIMER_MULTI_CAPTURE_EN
        if (t_clear) mCap = '0;
        else if (cap_in && !mCapPrev) mCap = mCount;
        mCapPrev = cap_in;
`endif
        if (t_clear) begin
            mCount = '0;
            mPcnt  = '0;
            mState = S_IDLE;
        end else if (t_load) begin
            mCount = load_val;
            mPcnt  = '0;
            mState = S_IDLE;
        end else if (mState == S_IDLE) begin
            if (t_en) mState = S_RUN;
        end else if (mState == S_RUN) begin
            nState = t_en ? S_RUN : S_IDLE;
            if (mPcnt >= prescale) begin
                mPcnt   = '0;
                e.valid = 1'b1;
                if (mCount == compare) begin
                    e.match = 1'b1;
                    if (mode) nState = S_DONE;
                    else mCount = '0;
                end else if (mCount == {WIDTH{1'b1}}) begin
                    mCount = '0;
                    e.ovf  = 1'b1;
                end else begin
                    mCount = mCount + 1'b1;
                end
            end else begin
                mPcnt = mPcnt + 1'b1;
            end
            mState = nState;
        end
        e.out  = mCount;
        e.done = (mState == S_DONE);
        e.cap  = mCap;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s observed=empty_queue required=entry", tag);
            return;
        end
        e = expQ.pop_front();
        cmp({tag, "_out"}, 32'(t_out), 32'(e.out));
        cmp({tag, "_flags"}, 32'({t_valid, t_match, t_ovf, t_done}),
            32'({e.valid, e.match, e.ovf, e.done}));
`ifdef TIMER_MULTI_CAPTURE_EN
        cmp({tag, "_cap"}, 32'(cap_out), 32'(e.cap));
`endif
    endtask

    task automatic stepN(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            checkOutput(tag);
        end
    endtask

    task automatic clearStep();
        t_en    = 1'b0;
        t_clear = 1'b1;
        applyStimulus();
        checkOutput("clear");
        t_clear = 1'b0;
    endtask

    task automatic runTo(input string tag, input logic [WIDTH-1:0] target);
        int n;
        n = 0;
        while (mCount != target && n < 40) begin
            applyStimulus();
            checkOutput(tag);
            n++;
        end
        if (mCount != target) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s observed=bound_expired required=count_%0d", tag, target);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] perOut[9]   = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic             perMatch[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        logic [WIDTH-1:0] osOut[13]   = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2};
        logic             osDone[13]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

        reset    = 1'b1;
        t_en     = 1'b0;
        t_clear  = 1'b0;
        t_load   = 1'b0;
        load_val = '0;
        prescale = '0;
        compare  = '0;
        mode     = 1'b0;
`ifdef TIMER_MULTI_CAPTURE_EN
        cap_in   = 1'b0;
`endif
        modelReset();
        @(posedge clock);
        #1;
        cmp("reset_out", 32'(t_out), 32'd0);
        cmp("reset_flags", 32'({t_valid, t_match, t_ovf, t_done}), 32'd0);
        reset = 1'b0;

        // Periodic, P=0, compare=3
        clearStep();
        mode = 1'b0; prescale = 4'd0; compare = 4'd3; t_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            checkOutput("periodic");
            cmp("periodic_tbl_out", 32'(t_out), 32'(perOut[i]));
            cmp("periodic_tbl_match", 32'(t_match), 32'(perMatch[i]));
        end

        // One-shot, P=2, compare=2
        clearStep();
        mode = 1'b1; prescale = 4'd2; compare = 4'd2; t_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus();
            checkOutput("oneshot");
            cmp("oneshot_tbl_out", 32'(t_out), 32'(osOut[i]));
            cmp("oneshot_tbl_done", 32'(t_done), 32'(osDone[i]));
        end
        t_en = 1'b0;
        stepN("oneshot_hold", 2);
        t_en = 1'b1;
        stepN("oneshot_hold_en", 2);
        clearStep();
        cmp("oneshot_cleared_done", 32'(t_done), 32'd0);

        // compare=all-ones from load 14: match wins over overflow
        mode = 1'b0; prescale = 4'd0; compare = 4'd15; t_en = 1'b1;
        t_load = 1'b1; load_val = 4'd14;
        applyStimulus();
        checkOutput("load14");
        t_load = 1'b0;
        stepN("cmp15", 3);
        cmp("cmp15_wrap_out", 32'(t_out), 32'd0);
        cmp("cmp15_wrap_mo", 32'({t_match, t_ovf}), 32'b10);

        // compare=3 from load 14: plain overflow, then match on next pass
        clearStep();
        compare = 4'd3; t_en = 1'b1;
        t_load = 1'b1; load_val = 4'd14;
        applyStimulus();
        checkOutput("load14b");
        t_load = 1'b0;
        stepN("cmp3", 3);
        cmp("cmp3_wrap_out", 32'(t_out), 32'd0);
        cmp("cmp3_wrap_mo", 32'({t_match, t_ovf}), 32'b01);
        stepN("cmp3_after", 5);

        // Clear beats load in the same cycle
        t_clear = 1'b1; t_load = 1'b1; load_val = 4'd9;
        applyStimulus();
        checkOutput("clear_vs_load");
        cmp("clear_vs_load_out", 32'(t_out), 32'd0);
        t_clear = 1'b0; t_load = 1'b0;

        // Pause with P=2: count and prescaler phase frozen
        prescale = 4'd2; compare = 4'd15; t_en = 1'b1;
        stepN("pause_pre", 7);
        t_en = 1'b0;
        stepN("pause_low", 4);
        t_en = 1'b1;
        stepN("pause_resume", 9);

        // Mid-run prescale decrease
        clearStep();
        prescale = 4'd7; t_en = 1'b1;
        stepN("ps_slow", 6);
        prescale = 4'd1;
        stepN("ps_fast", 8);

        // Compare moved below the current count: wrap, then match
        clearStep();
        prescale = 4'd0; compare = 4'd15; t_en = 1'b1;
        runTo("cmp_move_pre", 4'd10);
        compare = 4'd4;
        stepN("cmp_move", 14);

`ifdef TIMER_MULTI_CAPTURE_EN
        clearStep();
        prescale = 4'd0; compare = 4'd12; t_en = 1'b1;
        runTo("cap_pre", 4'd7);
        cap_in = 1'b1;
        applyStimulus();
        checkOutput("cap_edge");
        cmp("cap_value", 32'(cap_out), 32'd7);
        stepN("cap_high", 2);
        cap_in = 1'b0;
        stepN("cap_hold", 4);
        cmp("cap_held", 32'(cap_out), 32'd7);
`endif

        // Asynchronous reset mid-run at count 5
        clearStep();
        prescale = 4'd0; compare = 4'd12; mode = 1'b0; t_en = 1'b1;
        runTo("rst_pre", 4'd5);
        #2;
        reset = 1'b1;
        #1;
        cmp("async_reset_out", 32'(t_out), 32'd0);
        cmp("async_reset_flags", 32'({t_valid, t_match, t_ovf, t_done}), 32'd0);
`ifdef TIMER_MULTI_CAPTURE_EN
        cmp("async_reset_cap", 32'(cap_out), 32'd0);
`endif
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        stepN("post_reset", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
